// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: bundles the decode inputs, the memory ready handshake
// and all datapath control outputs of the multi-cycle MIPS controller.
// The master modport is the controller; the slave modport is the datapath.
// Optional macro MCTRL_BNE_EN adds the BranchNe_o signal.
interface multicycle_ctrl_if #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3
);
    // Decode and handshake inputs to the controller
    logic [OP_W-1:0]    instr_op_i;
    logic [FUNCT_W-1:0] function_i;
    logic               mem_ready_i;

    // Datapath control outputs
    logic               PCWrite_o;
    logic               Branch_o;
    logic [1:0]         PCSrc_o;
    logic               IRWrite_o;
    logic               MemRead_o;
    logic               MemWrite_o;
    logic               IorD_o;
    logic               RegWrite_o;
    logic [1:0]         RegDst_o;
    logic [1:0]         MemtoReg_o;
    logic               ALUSrcA_o;
    logic [1:0]         ALUSrcB_o;
    logic [ALUOP_W-1:0] ALU_op_o;
    logic [2:0]         state_o;
    logic               illegal_o;
    logic               mem_err_o;
`ifdef MCTRL_BNE_EN
    logic               BranchNe_o;
`endif

    modport master (
        input  instr_op_i, function_i, mem_ready_i,
`ifdef MCTRL_BNE_EN
        output BranchNe_o,
`endif
        output PCWrite_o, Branch_o, PCSrc_o, IRWrite_o, MemRead_o, MemWrite_o,
               IorD_o, RegWrite_o, RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, state_o, illegal_o, mem_err_o
    );

    modport slave (
        output instr_op_i, function_i, mem_ready_i,
`ifdef MCTRL_BNE_EN
        input  BranchNe_o,
`endif
        input  PCWrite_o, Branch_o, PCSrc_o, IRWrite_o, MemRead_o, MemWrite_o,
               IorD_o, RegWrite_o, RegDst_o, MemtoReg_o, ALUSrcA_o, ALUSrcB_o,
               ALU_op_o, state_o, illegal_o, mem_err_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for the multi-cycle MIPS datapath.
// Sequences IF/ID/EX/MEM/WB, stalls on mem_ready_i with an optional
// wait-state timeout, and decodes all datapath enables combinationally
// from the registered state plus the current opcode/funct.
// Optional macro MCTRL_BNE_EN: decode bne (000101) and drive BranchNe_o.
module multicycle_ctrl #(
    parameter int OP_W    = 6,
    parameter int FUNCT_W = 6,
    parameter int ALUOP_W = 3,
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    multicycle_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    localparam logic [OP_W-1:0]    OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0]    OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0]    OP_SLTI  = OP_W'(6'b001010);
    localparam logic [OP_W-1:0]    OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0]    OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0]    OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0]    OP_J     = OP_W'(6'b000010);
    localparam logic [OP_W-1:0]    OP_JAL   = OP_W'(6'b000011);
`ifdef MCTRL_BNE_EN
    localparam logic [OP_W-1:0]    OP_BNE   = OP_W'(6'b000101);
`endif
    localparam logic [FUNCT_W-1:0] FN_JR    = FUNCT_W'(6'b001000);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b011);

    // A zero TIMEOUT disables the wait-state abort entirely.
    localparam bit               TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    // Instruction class decode
    logic is_rtype, is_jr, is_addi, is_slti, is_lw, is_sw;
    logic is_beq, is_bne, is_branch, is_j, is_jal, is_ex_class;
    logic timeout_hit;

    // Combinational control values before reset gating
    logic               pc_write;
    logic               branch;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               reg_write;
    logic [1:0]         reg_dst;
    logic [1:0]         mem_to_reg;
    logic               alu_src_a;
    logic [1:0]         alu_src_b;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
    logic               mem_err;
`ifdef MCTRL_BNE_EN
    logic               branch_ne;
`endif

    // Classify the opcode/funct currently presented by the IR
    always_comb begin
        is_rtype  = (bus.instr_op_i == OP_RTYPE) && (bus.function_i != FN_JR);
        is_jr     = (bus.instr_op_i == OP_RTYPE) && (bus.function_i == FN_JR);
        is_addi   = (bus.instr_op_i == OP_ADDI);
        is_slti   = (bus.instr_op_i == OP_SLTI);
        is_lw     = (bus.instr_op_i == OP_LW);
        is_sw     = (bus.instr_op_i == OP_SW);
        is_beq    = (bus.instr_op_i == OP_BEQ);
`ifdef MCTRL_BNE_EN
        is_bne    = (bus.instr_op_i == OP_BNE);
`else
        is_bne    = 1'b0;
`endif
        is_j      = (bus.instr_op_i == OP_J);
        is_jal    = (bus.instr_op_i == OP_JAL);
        is_branch = is_beq | is_bne;
        is_ex_class = is_rtype | is_addi | is_slti | is_lw | is_sw | is_branch;
    end

    // Wait-state limit reached on the current stalled memory cycle
    assign timeout_hit = TIMEOUT_EN && (cnt_q == TIMEOUT_C);

    // Next-state, wait counter and control decode for the current state
    always_comb begin
        state_d    = state_q;
        cnt_d      = '0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 2'd0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'd0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        mem_err    = 1'b0;
`ifdef MCTRL_BNE_EN
        branch_ne  = 1'b0;
`endif
        case (state_q)
            S_IF: begin
                // Fetch at PC while the ALU computes PC+4
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (bus.mem_ready_i) begin
                    // Ready in the timeout cycle still completes normally
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_ID;
                end else if (timeout_hit) begin
                    // Abort the fetch; re-entering IF restarts the count
                    mem_err = 1'b1;
                    state_d = S_IF;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ID: begin
                // Branch target PC + (imm<<2) is precomputed into ALUOut
                alu_src_b = 2'd3;
                if (is_jr) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd3;
                    state_d  = S_IF;
                end else if (is_j) begin
                    pc_write = 1'b1;
                    pc_src   = 2'd2;
                    state_d  = S_IF;
                end else if (is_jal) begin
                    // The PC update for jal happens alongside the link write
                    state_d = S_WB;
                end else if (is_ex_class) begin
                    state_d = S_EX;
                end else begin
                    illegal = 1'b1;
                    state_d = S_IF;
                end
            end
            S_EX: begin
                if (is_rtype) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd0;
                    alu_op    = ALU_FUNCT;
                    state_d   = S_WB;
                end else if (is_addi) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    state_d   = S_WB;
                end else if (is_lw || is_sw) begin
                    // Effective address rs + sign-extended offset
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    state_d   = S_MEM;
                end else if (is_slti) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd2;
                    alu_op    = ALU_SLT;
                    state_d   = S_WB;
                end else if (is_branch) begin
                    // Compare rs-rt; PC loads the precomputed target from ALUOut
                    alu_src_a = 1'b1;
                    alu_src_b = 2'd0;
                    alu_op    = ALU_SUB;
                    branch    = 1'b1;
                    pc_src    = 2'd1;
`ifdef MCTRL_BNE_EN
                    branch_ne = is_bne;
`endif
                    state_d   = S_IF;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                iord = 1'b1;
                if (is_lw || is_sw) begin
                    mem_read  = is_lw;
                    mem_write = is_sw;
                    if (bus.mem_ready_i) begin
                        state_d = is_lw ? S_WB : S_IF;
                    end else if (timeout_hit) begin
                        mem_err = 1'b1;
                        state_d = S_IF;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                reg_write = 1'b1;
                if (is_rtype) begin
                    reg_dst = 2'd1;
                end else if (is_lw) begin
                    mem_to_reg = 2'd1;
                end else if (is_jal) begin
                    // Link PC into $31 and jump in the same cycle
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                end
                state_d = S_IF;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
    end

    // State and wait-counter registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= S_IF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // All outputs are forced low while reset is asserted, dropping any strobe
    assign bus.PCWrite_o  = rst_i & pc_write;
    assign bus.Branch_o   = rst_i & branch;
    assign bus.PCSrc_o    = rst_i ? pc_src : 2'd0;
    assign bus.IRWrite_o  = rst_i & ir_write;
    assign bus.MemRead_o  = rst_i & mem_read;
    assign bus.MemWrite_o = rst_i & mem_write;
    assign bus.IorD_o     = rst_i & iord;
    assign bus.RegWrite_o = rst_i & reg_write;
    assign bus.RegDst_o   = rst_i ? reg_dst : 2'd0;
    assign bus.MemtoReg_o = rst_i ? mem_to_reg : 2'd0;
    assign bus.ALUSrcA_o  = rst_i & alu_src_a;
    assign bus.ALUSrcB_o  = rst_i ? alu_src_b : 2'd0;
    assign bus.ALU_op_o   = rst_i ? alu_op : '0;
    assign bus.state_o    = rst_i ? state_q : 3'd0;
    assign bus.illegal_o  = rst_i & illegal;
    assign bus.mem_err_o  = rst_i & mem_err;
`ifdef MCTRL_BNE_EN
    assign bus.BranchNe_o = rst_i & branch_ne;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed self-checking bench for multicycle_ctrl.
// Inputs change just after the falling edge; outputs are sampled 1 time
// unit later, well away from the rising edge.
module tb_multicycle_ctrl;
    localparam int TIMEOUT = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BAD  = 6'b111111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OP_W(6), .FUNCT_W(6), .ALUOP_W(3)) bus ();

    multicycle_ctrl #(
        .OP_W(6), .FUNCT_W(6), .ALUOP_W(3), .TIMEOUT(TIMEOUT), .CNT_W(4)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Every output packed into one word for the all-zero reset check
    function automatic logic [31:0] all_outs();
        logic [31:0] v;
        v = {7'd0,
`ifdef MCTRL_BNE_EN
             bus.BranchNe_o,
`else
             1'b0,
`endif
             bus.PCWrite_o, bus.Branch_o, bus.PCSrc_o, bus.IRWrite_o,
             bus.MemRead_o, bus.MemWrite_o, bus.IorD_o, bus.RegWrite_o,
             bus.RegDst_o, bus.MemtoReg_o, bus.ALUSrcA_o, bus.ALUSrcB_o,
             bus.ALU_op_o, bus.state_o, bus.illegal_o, bus.mem_err_o};
        return v;
    endfunction

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.mem_ready_i = 1'b1;
        bus.instr_op_i  = OP_LW;
        bus.function_i  = FN_ADD;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            n_vec++;
            if (all_outs() !== 32'd0) begin
                n_err++;
                $display("FAIL reset_outs cyc%0d: got %08h expected 00000000", i, all_outs());
            end
        end
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready_i = 1'b0;
        #1;
        n_vec++;
        if (bus.state_o !== 3'd0 || bus.MemRead_o !== 1'b1 || bus.IRWrite_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got state=%0d MemRead=%b IRWrite=%b expected 0 1 0",
                     bus.state_o, bus.MemRead_o, bus.IRWrite_o);
        end
        $display("reset: released into IF");
    endtask

    task automatic test_rtype_add();
        logic [2:0] exp_st [5];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
        bus.instr_op_i  = OP_R;
        bus.function_i  = FN_ADD;
        bus.mem_ready_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) next_cycle();
            n_vec++;
            if (bus.state_o !== exp_st[i] || bus.RegWrite_o !== (exp_st[i] == 3'd4)) begin
                n_err++;
                $display("FAIL add_seq step%0d: got state=%0d RegWrite=%b expected state=%0d RegWrite=%b",
                         i, bus.state_o, bus.RegWrite_o, exp_st[i], exp_st[i] == 3'd4);
            end
            if (exp_st[i] == 3'd2) begin
                n_vec++;
                if (bus.ALU_op_o !== 3'b010 || bus.ALUSrcA_o !== 1'b1 || bus.ALUSrcB_o !== 2'd0) begin
                    n_err++;
                    $display("FAIL add_ex: got op=%0d srcA=%b srcB=%0d expected 2 1 0",
                             bus.ALU_op_o, bus.ALUSrcA_o, bus.ALUSrcB_o);
                end
            end
            if (exp_st[i] == 3'd4) begin
                n_vec++;
                if (bus.RegDst_o !== 2'd1 || bus.MemtoReg_o !== 2'd0) begin
                    n_err++;
                    $display("FAIL add_wb: got RegDst=%0d MemtoReg=%0d expected 1 0",
                             bus.RegDst_o, bus.MemtoReg_o);
                end
            end
        end
        $display("add: states 0,1,2,4,0 walked");
    endtask

    task automatic test_lw_wait();
        int cyc = 0;
        int mr = 0;
        int stall = 0;
        logic [1:0] wb_mtr = 2'd3;
        bus.instr_op_i  = OP_LW;
        bus.mem_ready_i = 1'b1;
        #1;
        do begin
            @(negedge clk);
            if (bus.state_o == 3'd3) begin
                bus.mem_ready_i = (stall == 3);
                stall++;
            end else begin
                bus.mem_ready_i = (bus.state_o == 3'd2) ? 1'b0 : 1'b1;
            end
            #1;
            cyc++;
            if (bus.state_o == 3'd3 && bus.MemRead_o === 1'b1 && bus.IorD_o === 1'b1) mr++;
            if (bus.state_o == 3'd4) wb_mtr = bus.MemtoReg_o;
        end while (bus.state_o != 3'd0 && cyc < 30);
        n_vec++;
        if (cyc != 8) begin
            n_err++;
            $display("FAIL lw_latency: got %0d cycles expected 8", cyc);
        end
        n_vec++;
        if (mr != 4) begin
            n_err++;
            $display("FAIL lw_memread_hold: got %0d cycles expected 4", mr);
        end
        n_vec++;
        if (wb_mtr !== 2'd1) begin
            n_err++;
            $display("FAIL lw_wb_memtoreg: got %0d expected 1", wb_mtr);
        end
        $display("lw: 3 wait states, %0d cycles", cyc);
    endtask

    task automatic test_if_timeout();
        bus.instr_op_i  = OP_R;
        bus.mem_ready_i = 1'b0;
        #1;
        for (int i = 0; i <= TIMEOUT + 1; i++) begin
            if (i > 0) next_cycle();
            n_vec++;
            if (bus.mem_err_o !== (i == TIMEOUT) || bus.IRWrite_o !== 1'b0 || bus.state_o !== 3'd0) begin
                n_err++;
                $display("FAIL if_timeout wait%0d: got mem_err=%b IRWrite=%b state=%0d expected %b 0 0",
                         i, bus.mem_err_o, bus.IRWrite_o, bus.state_o, i == TIMEOUT);
            end
        end
        $display("if_timeout: mem_err pulse at wait %0d", TIMEOUT);
    endtask

    task automatic test_ready_wins();
        bus.instr_op_i  = OP_J;
        bus.mem_ready_i = 1'b0;
        #1;
        for (int i = 0; i < TIMEOUT; i++) next_cycle();
        bus.mem_ready_i = 1'b1;
        #1;
        n_vec++;
        if (bus.mem_err_o !== 1'b0 || bus.IRWrite_o !== 1'b1 || bus.PCWrite_o !== 1'b1) begin
            n_err++;
            $display("FAIL ready_wins: got mem_err=%b IRWrite=%b PCWrite=%b expected 0 1 1",
                     bus.mem_err_o, bus.IRWrite_o, bus.PCWrite_o);
        end
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd1 || bus.PCWrite_o !== 1'b1 || bus.PCSrc_o !== 2'd2) begin
            n_err++;
            $display("FAIL j_id: got state=%0d PCWrite=%b PCSrc=%0d expected 1 1 2",
                     bus.state_o, bus.PCWrite_o, bus.PCSrc_o);
        end
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd0) begin
            n_err++;
            $display("FAIL j_return: got state=%0d expected 0", bus.state_o);
        end
        $display("ready_wins: fetch completes on timeout cycle, j taken");
    endtask

    task automatic test_sw_mem_timeout();
        int rw = 0;
        bus.instr_op_i  = OP_SW;
        bus.mem_ready_i = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        bus.mem_ready_i = 1'b0;
        for (int i = 0; i <= TIMEOUT; i++) begin
            next_cycle();
            if (bus.RegWrite_o === 1'b1) rw++;
            n_vec++;
            if (bus.state_o !== 3'd3 || bus.MemWrite_o !== 1'b1 || bus.mem_err_o !== (i == TIMEOUT)) begin
                n_err++;
                $display("FAIL sw_mem_timeout wait%0d: got state=%0d MemWrite=%b mem_err=%b expected 3 1 %b",
                         i, bus.state_o, bus.MemWrite_o, bus.mem_err_o, i == TIMEOUT);
            end
        end
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd0 || bus.MemWrite_o !== 1'b0 || bus.mem_err_o !== 1'b0 || rw != 0) begin
            n_err++;
            $display("FAIL sw_abort: got state=%0d MemWrite=%b mem_err=%b regwrites=%0d expected 0 0 0 0",
                     bus.state_o, bus.MemWrite_o, bus.mem_err_o, rw);
        end
        $display("sw_mem_timeout: store aborted after %0d waits", TIMEOUT);
    endtask

    task automatic test_illegal();
        logic [5:0] bad_ops [2];
`ifdef MCTRL_BNE_EN
        bad_ops = '{OP_BAD, 6'b111110};
`else
        bad_ops = '{OP_BAD, OP_BNE};
`endif
        for (int k = 0; k < 2; k++) begin
            bus.instr_op_i  = bad_ops[k];
            bus.mem_ready_i = 1'b1;
            #1;
            next_cycle();
            n_vec++;
            if (bus.state_o !== 3'd1 || bus.illegal_o !== 1'b1 || bus.PCWrite_o !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_id op=%06b: got state=%0d illegal=%b PCWrite=%b expected 1 1 0",
                         bad_ops[k], bus.state_o, bus.illegal_o, bus.PCWrite_o);
            end
            next_cycle();
            n_vec++;
            if (bus.state_o !== 3'd0 || bus.illegal_o !== 1'b0) begin
                n_err++;
                $display("FAIL illegal_return op=%06b: got state=%0d illegal=%b expected 0 0",
                         bad_ops[k], bus.state_o, bus.illegal_o);
            end
            $display("illegal: op %06b flagged", bad_ops[k]);
        end
    endtask

    task automatic test_jal();
        bus.instr_op_i  = OP_JAL;
        bus.mem_ready_i = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd4 || bus.RegDst_o !== 2'd2 || bus.MemtoReg_o !== 2'd2 ||
            bus.PCSrc_o !== 2'd2 || bus.PCWrite_o !== 1'b1 || bus.RegWrite_o !== 1'b1) begin
            n_err++;
            $display("FAIL jal_wb: got st=%0d RegDst=%0d MemtoReg=%0d PCSrc=%0d PCWrite=%b RegWrite=%b expected 4 2 2 2 1 1",
                     bus.state_o, bus.RegDst_o, bus.MemtoReg_o, bus.PCSrc_o, bus.PCWrite_o, bus.RegWrite_o);
        end
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd0 || bus.RegWrite_o !== 1'b0) begin
            n_err++;
            $display("FAIL jal_return: got state=%0d RegWrite=%b expected 0 0", bus.state_o, bus.RegWrite_o);
        end
        $display("jal: link written in WB");
    endtask

    task automatic test_branch();
        logic [5:0] br_ops [2];
        int nb;
        br_ops = '{OP_BEQ, OP_BNE};
`ifdef MCTRL_BNE_EN
        nb = 2;
`else
        nb = 1;
`endif
        for (int k = 0; k < nb; k++) begin
            int brc = 0;
            int cyc = 0;
            bus.instr_op_i  = br_ops[k];
            bus.mem_ready_i = 1'b1;
            #1;
            if (bus.Branch_o === 1'b1) brc++;
            do begin
                next_cycle();
                cyc++;
                if (bus.Branch_o === 1'b1) brc++;
                if (bus.state_o == 3'd2) begin
                    n_vec++;
                    if (bus.Branch_o !== 1'b1 || bus.PCSrc_o !== 2'd1 || bus.ALU_op_o !== 3'b001) begin
                        n_err++;
                        $display("FAIL branch_ex op=%06b: got Branch=%b PCSrc=%0d op=%0d expected 1 1 1",
                                 br_ops[k], bus.Branch_o, bus.PCSrc_o, bus.ALU_op_o);
                    end
`ifdef MCTRL_BNE_EN
                    n_vec++;
                    if (bus.BranchNe_o !== (br_ops[k] == OP_BNE)) begin
                        n_err++;
                        $display("FAIL branch_ne op=%06b: got %b expected %b",
                                 br_ops[k], bus.BranchNe_o, br_ops[k] == OP_BNE);
                    end
`endif
                end
            end while (bus.state_o != 3'd0 && cyc < 20);
            n_vec++;
            if (cyc != 3 || brc != 1) begin
                n_err++;
                $display("FAIL branch_seq op=%06b: got %0d cycles %0d Branch cycles expected 3 1",
                         br_ops[k], cyc, brc);
            end
            $display("branch: op %06b took %0d cycles", br_ops[k], cyc);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops   [9];
        logic [5:0] fns   [9];
        int         lats  [9];
        logic [2:0] exops [9];
        ops   = '{OP_ADDI, OP_SLTI, OP_SW, OP_R,   OP_R,  OP_BEQ, OP_LW,  OP_J,   OP_JAL};
        fns   = '{FN_ADD,  FN_ADD,  FN_ADD, FN_SUB, FN_JR, FN_ADD, FN_ADD, FN_ADD, FN_ADD};
        lats  = '{4, 4, 4, 4, 2, 3, 5, 2, 3};
        exops = '{3'd0, 3'd3, 3'd0, 3'd2, 3'd7, 3'd1, 3'd0, 3'd7, 3'd7};
        bus.mem_ready_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            int cyc = 0;
            logic [2:0] seen = 3'd7;
            bus.instr_op_i = ops[k];
            bus.function_i = fns[k];
            #1;
            do begin
                next_cycle();
                cyc++;
                if (bus.state_o == 3'd2) seen = bus.ALU_op_o;
            end while (bus.state_o != 3'd0 && cyc < 20);
            n_vec++;
            if (cyc != lats[k] || seen !== exops[k]) begin
                n_err++;
                $display("FAIL b2b op=%06b fn=%06b: got lat=%0d exop=%0d expected lat=%0d exop=%0d",
                         ops[k], fns[k], cyc, seen, lats[k], exops[k]);
            end
            $display("b2b: op=%06b fn=%06b latency %0d", ops[k], fns[k], cyc);
        end
    endtask

    task automatic test_reset_mid_access();
        bus.instr_op_i  = OP_LW;
        bus.mem_ready_i = 1'b1;
        #1;
        next_cycle();
        next_cycle();
        bus.mem_ready_i = 1'b0;
        next_cycle();
        n_vec++;
        if (bus.state_o !== 3'd3 || bus.MemRead_o !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_mem: got state=%0d MemRead=%b expected 3 1", bus.state_o, bus.MemRead_o);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (all_outs() !== 32'd0) begin
            n_err++;
            $display("FAIL midrst_drop: got %08h expected 00000000", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_vec++;
        if (bus.state_o !== 3'd0 || bus.MemRead_o !== 1'b1 || bus.IorD_o !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_release: got state=%0d MemRead=%b IorD=%b expected 0 1 0",
                     bus.state_o, bus.MemRead_o, bus.IorD_o);
        end
        $display("reset_mid_access: strobes dropped, back in IF");
    endtask

    initial begin
        bus.instr_op_i  = OP_R;
        bus.function_i  = FN_ADD;
        bus.mem_ready_i = 1'b0;
        test_reset();
        test_rtype_add();
        test_lw_wait();
        test_if_timeout();
        test_ready_wins();
        test_sw_mem_timeout();
        test_illegal();
        test_jal();
        test_branch();
        test_back_to_back();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Absolute bound so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
